// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction decode with a valid/ready handshake.
// The decoded entry is computed from instr_i and stored in a one- or two-entry
// buffer. The head entry drives all outputs directly from flops.
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int SKID_DEPTH   = 2,
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      op_code_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    localparam bit USE_SKID = (SKID_DEPTH >= 2);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            ill;
    } entry_t;

    // Widen a 32-bit immediate to XLEN, replicating bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Full-format field and immediate decode of one instruction word.
    function automatic entry_t decode(input logic [31:0] ins);
        entry_t     e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm_i;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        e     = '0;
        e.op  = ins[6:0];
        e.f3  = f3;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.ill = 1'b0;
        case (ins[6:0])
            OP_R: begin
                e.rs2 = ins[24:20];
                e.f7  = f7;
                if (f7 == 7'b0000000) begin
                    e.ill = 1'b0;
                end else if (f7 == 7'b0100000) begin
                    e.ill = !((f3 == 3'b000) || (f3 == 3'b101));
                end else begin
                    e.ill = 1'b1;
                end
            end
            OP_IMM: begin
                if (f3 == 3'b001) begin
                    e.f7  = f7;
                    e.imm = sext32({27'd0, ins[24:20]});
                    e.ill = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    e.f7  = f7;
                    e.imm = sext32({27'd0, ins[24:20]});
                    e.ill = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
                end else begin
                    e.imm = sext32(imm_i);
                end
            end
            OP_LOAD: begin
                e.imm = sext32(imm_i);
                e.ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                e.rd  = 5'd0;
                e.rs2 = ins[24:20];
                e.imm = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
                e.ill = (f3 >= 3'b011);
            end
            OP_BRANCH: begin
                e.rd  = 5'd0;
                e.rs2 = ins[24:20];
                e.imm = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                e.ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_JALR: begin
                e.imm = sext32(imm_i);
                e.ill = (f3 != 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                e.f3  = 3'd0;
                e.rs1 = 5'd0;
                e.imm = sext32({ins[31:12], 12'd0});
            end
            OP_JAL: begin
                e.f3  = 3'd0;
                e.rs1 = 5'd0;
                e.imm = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            end
            OP_FENCE: begin
                e.rd  = 5'd0;
                e.imm = sext32(imm_i);
            end
            OP_SYSTEM: begin
                e.imm = sext32(imm_i);
            end
            default: begin
                e.ill = 1'b1;
            end
        endcase
        if (ins[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            e.ill = e.ill;
        end
        if (ILLEGAL_ZERO && e.ill) begin
            e.rd  = 5'd0;
            e.rs1 = 5'd0;
            e.rs2 = 5'd0;
            e.f7  = 7'd0;
            e.imm = '0;
        end else begin
            e.rd = e.rd;
        end
        return e;
    endfunction

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    entry_t dec_s;
    logic   accept_s;
    logic   pop_s;

    // Depth 2 exposes the registered "skid slot free" flag; depth 1 frees on pop.
    assign in_ready_o = USE_SKID ? in_ready_q : (!head_valid_q || out_ready_i);

    // Decode the incoming word and work out handshake events and buffer next state.
    always_comb begin
        dec_s        = decode(instr_i);
        dec_s.pc     = pc_i;
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        accept_s     = in_valid_i && in_ready_o && !flush_i;
        pop_s        = head_valid_q && out_ready_i;
        if (flush_i) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop_s || !head_valid_q) begin
            // Head slot is free this edge: refill from the skid slot first, then the input.
            if (skid_valid_q) begin
                head_d       = skid_q;
                head_valid_d = 1'b1;
                if (accept_s) begin
                    skid_d       = dec_s;
                    skid_valid_d = 1'b1;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (accept_s) begin
                head_d       = dec_s;
                head_valid_d = 1'b1;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (accept_s && USE_SKID) begin
            // Head is stalled: park the new entry behind it.
            skid_d       = dec_s;
            skid_valid_d = 1'b1;
        end else begin
            skid_valid_d = skid_valid_q;
        end
        in_ready_d = !skid_valid_d;
    end

    // Buffer state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign out_valid_o = head_valid_q;
    assign pc_o        = head_q.pc;
    assign op_code_o   = head_q.op;
    assign funct3_o    = head_q.f3;
    assign funct7_o    = head_q.f7;
    assign rd_o        = head_q.rd;
    assign rs1_o       = head_q.rs1;
    assign rs2_o       = head_q.rs2;
    assign imm_o       = head_q.imm;
    assign illegal_o   = head_q.ill;

endmodule
